// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec
//  Purpose  : Single-issue integer execute stage. Eight single-cycle ops
//             (ADD, SUB, AND, OR, XOR, SLT, SLL, SRL) and an optional
//             32-cycle shift-add multiplier. Results are written back to the
//             register file through a registered one-cycle write strobe.
//
//  Ports    : CLK        in   1   clock, all state on posedge
//             reset      in   1   asynchronous active-low reset
//             in_valid   in   1   operation presented
//             in_ready   out  1   operation can be accepted this cycle
//             op         in   4   opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR,
//                                 5 SLT, 6 SLL, 7 SRL, 8 MUL, 9-15 illegal
//             rs_data    in   32  operand A (shift amount for SLL/SRL)
//             rt_data    in   32  operand B (value shifted for SLL/SRL)
//             dest_addr  in   5   destination register (0 = discard)
//             regWr      out  1   one-cycle register-file write strobe
//             WriteAddr  out  5   write destination (holds last value)
//             WriteData  out  32  write result (holds last value)
//             busy       out  1   multiply in progress
//             err        out  1   one-cycle pulse on illegal opcode
//
//  Build    : define ALU_EXEC_MUL_EN to include the MUL op and its IDLE/MUL
//             state machine. Without it op 8 is illegal, busy is tied low
//             and in_ready follows reset.
//
//  Revision : 1.0  initial release
// ============================================================================
module alu_exec (
    input  logic        CLK,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [4:0]  dest_addr,
    output logic        regWr,
    output logic [4:0]  WriteAddr,
    output logic [31:0] WriteData,
    output logic        busy,
    output logic        err
);

    localparam logic [3:0] c_OP_ADD = 4'd0;
    localparam logic [3:0] c_OP_SUB = 4'd1;
    localparam logic [3:0] c_OP_AND = 4'd2;
    localparam logic [3:0] c_OP_OR  = 4'd3;
    localparam logic [3:0] c_OP_XOR = 4'd4;
    localparam logic [3:0] c_OP_SLT = 4'd5;
    localparam logic [3:0] c_OP_SLL = 4'd6;
    localparam logic [3:0] c_OP_SRL = 4'd7;
`ifdef ALU_EXEC_MUL_EN
    localparam logic [3:0] c_OP_MUL = 4'd8;
`endif

    logic        r_regWr;
    logic        r_err;
    logic [4:0]  r_writeAddr;
    logic [31:0] r_writeData;

    logic        w_accept;
    logic        w_isMul;
    logic        w_legal;
    logic [31:0] w_aluResult;

    // ------------------------------------------------------------------
    // Single-cycle result
    // ------------------------------------------------------------------
    always_comb begin
        w_aluResult = 32'd0;
        case (op)
            c_OP_ADD: w_aluResult = rs_data + rt_data;
            c_OP_SUB: w_aluResult = rs_data - rt_data;
            c_OP_AND: w_aluResult = rs_data & rt_data;
            c_OP_OR:  w_aluResult = rs_data | rt_data;
            c_OP_XOR: w_aluResult = rs_data ^ rt_data;
            c_OP_SLT: w_aluResult = {31'd0, ($signed(rs_data) < $signed(rt_data))};
            c_OP_SLL: w_aluResult = rt_data << rs_data[4:0];
            c_OP_SRL: w_aluResult = rt_data >> rs_data[4:0];
            default:  w_aluResult = 32'd0;
        endcase
    end

`ifdef ALU_EXEC_MUL_EN
    // ------------------------------------------------------------------
    // IDLE/MUL state machine and shift-add multiplier
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [31:0] r_acc;
    logic [4:0]  r_count;
    logic [4:0]  r_mulDest;
    logic [31:0] w_mulStep;
    logic        w_mulDone;

    // Accept is formed from the state register directly rather than from
    // in_ready so the next-state logic has no combinational self-reference.
    assign w_accept  = in_valid & reset & (r_state == ST_IDLE);
    assign w_isMul   = (op == c_OP_MUL);
    assign w_legal   = (op <= c_OP_MUL);
    assign w_mulStep = r_acc + (r_mplier[0] ? r_mcand : 32'd0);
    // Last iteration: the final partial product is folded straight into
    // the write-back data on the same edge that returns to IDLE.
    assign w_mulDone = (r_state == ST_MUL) && (r_count == 5'd31);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = reset;
                if (w_accept && w_isMul) begin
                    w_stateNext = ST_MUL;
                end
            end
            ST_MUL: begin
                busy = 1'b1;
                if (r_count == 5'd31) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_mcand   <= 32'd0;
            r_mplier  <= 32'd0;
            r_acc     <= 32'd0;
            r_count   <= 5'd0;
            r_mulDest <= 5'd0;
        end else if (r_state == ST_IDLE) begin
            if (w_accept && w_isMul) begin
                r_mcand   <= rs_data;
                r_mplier  <= rt_data;
                r_acc     <= 32'd0;
                r_count   <= 5'd0;
                r_mulDest <= dest_addr;
            end
        end else begin
            r_acc    <= w_mulStep;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 5'd1;
        end
    end
`else
    assign w_accept = in_valid & reset;
    assign w_isMul  = 1'b0;
    assign w_legal  = (op <= c_OP_SRL);
    assign in_ready = reset;
    assign busy     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Write-back / error registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_regWr     <= 1'b0;
            r_err       <= 1'b0;
            r_writeAddr <= 5'd0;
            r_writeData <= 32'd0;
        end else begin
            r_regWr <= 1'b0;
            r_err   <= 1'b0;
            if (w_accept) begin
                if (!w_legal) begin
                    // Illegal op: write-back registers keep their value.
                    r_err <= 1'b1;
                end else if (!w_isMul) begin
                    // Register 0 is never written, but the result still
                    // appears on WriteAddr/WriteData.
                    r_regWr     <= (dest_addr != 5'd0);
                    r_writeAddr <= dest_addr;
                    r_writeData <= w_aluResult;
                end
            end
`ifdef ALU_EXEC_MUL_EN
            // Cannot coincide with an accept: in_ready is low in MUL.
            if (w_mulDone) begin
                r_regWr     <= (r_mulDest != 5'd0);
                r_writeAddr <= r_mulDest;
                r_writeData <= w_mulStep;
            end
`endif
        end
    end

    assign regWr     = r_regWr;
    assign err       = r_err;
    assign WriteAddr = r_writeAddr;
    assign WriteData = r_writeData;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_exec
//  Purpose  : Directed self-checking bench for alu_exec. Expected write-backs
//             are queued when an op is driven and popped when regWr fires.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_exec;

    logic        CLK;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [4:0]  dest_addr;
    logic        regWr;
    logic [4:0]  WriteAddr;
    logic [31:0] WriteData;
    logic        busy;
    logic        err;

    alu_exec u_dut (
        .CLK       (CLK),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .dest_addr (dest_addr),
        .regWr     (regWr),
        .WriteAddr (WriteAddr),
        .WriteData (WriteData),
        .busy      (busy),
        .err       (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb[$];
    int          nCompared;
    int          nMismatch;
    logic        wrExp;
    logic        errExp;
    logic [4:0]  lastAddr;
    logic [31:0] lastData;

`ifdef ALU_EXEC_MUL_EN
    localparam bit c_MUL_EN = 1'b1;
`else
    localparam bit c_MUL_EN = 1'b0;
`endif

    function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        case (o)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: return b << a[4:0];
            4'd7: return b >> a[4:0];
            4'd8: begin
                p = {32'd0, a} * {32'd0, b};
                return p[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nCompared++;
        assert (obs === expv) else begin
            nMismatch++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Advance one edge, sample 1ns later, and reconcile strobes with the
    // bench's expectations and the scoreboard.
    task automatic tick();
        wr_t e;
        @(posedge CLK);
        #1;
        check("regWr", {31'd0, regWr}, {31'd0, wrExp});
        check("err", {31'd0, err}, {31'd0, errExp});
        if (regWr === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_empty_on_write", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("WriteAddr", {27'd0, WriteAddr}, {27'd0, e.addr});
                check("WriteData", WriteData, e.data);
            end
        end
        wrExp  = 1'b0;
        errExp = 1'b0;
    endtask

    // Present a single-cycle (or illegal) op; accepted on the next edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d);
        logic legal;
        op        = o;
        rs_data   = a;
        rt_data   = b;
        dest_addr = d;
        in_valid  = 1'b1;
        legal     = (o <= 4'd7);
        if (legal) begin
            wrExp    = (d != 5'd0);
            lastAddr = d;
            lastData = model(o, a, b);
            if (d != 5'd0) sb.push_back('{addr: d, data: lastData});
        end else begin
            errExp = 1'b1;
        end
        tick();
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_regWr"}, {31'd0, regWr}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_WriteAddr"}, {27'd0, WriteAddr}, 32'd0);
        check({tag, "_WriteData"}, WriteData, 32'd0);
    endtask

    initial begin
        nCompared = 0;
        nMismatch = 0;
        wrExp     = 1'b0;
        errExp    = 1'b0;
        lastAddr  = 5'd0;
        lastData  = 32'd0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        op        = 4'd0;
        rs_data   = 32'd0;
        rt_data   = 32'd0;
        dest_addr = 5'd0;

        // Reset state
        #2;
        checkResetOutputs("rst0");
        tick();
        tick();
        checkResetOutputs("rst1");
        reset = 1'b1;
        #1;
        check("ready_after_rst", {31'd0, in_ready}, 32'd1);
        check("busy_after_rst", {31'd0, busy}, 32'd0);

        // ADD wraps into the sign bit
        issue(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd3);
        check("add_data", WriteData, 32'h8000_0000);
        check("add_sb_drained", sb.size(), 32'd0);

        // Back-to-back single-cycle ops
        issue(4'd1, 32'h0000_0000, 32'h0000_0001, 5'd8);   // SUB wraps to all-ones
        issue(4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd9);   // AND
        issue(4'd3, 32'hF000_0000, 32'h0000_000F, 5'd10);  // OR
        issue(4'd4, 32'hAAAA_5555, 32'hFFFF_FFFF, 5'd11);  // XOR
        issue(4'd5, 32'hFFFF_FFFF, 32'h0000_0001, 5'd4);   // SLT -1 < 1
        check("slt_true", WriteData, 32'd1);
        issue(4'd5, 32'h0000_0005, 32'hFFFF_FFFD, 5'd12);  // SLT 5 < -3
        check("slt_false", WriteData, 32'd0);
        issue(4'd6, 32'h0000_003F, 32'h0000_0001, 5'd13);  // SLL by 31 (upper bits ignored)
        check("sll_31", WriteData, 32'h8000_0000);
        issue(4'd7, 32'h0000_0004, 32'h8000_0000, 5'd14);  // SRL logical
        check("srl_data", WriteData, 32'h0800_0000);
        check("b2b_sb_drained", sb.size(), 32'd0);

        // Illegal op: err pulse, write-back registers untouched
        issue(4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 5'd5);
        check("illegal_data_held", WriteData, lastData);
        check("illegal_addr_held", {27'd0, WriteAddr}, {27'd0, lastAddr});
        in_valid = 1'b0;
        tick();
        check("err_one_cycle", {31'd0, err}, 32'd0);

        // dest 0: result visible, no strobe
        issue(4'd0, 32'h0000_1000, 32'h0000_0234, 5'd0);
        check("dest0_data", WriteData, 32'h0000_1234);
        check("dest0_addr", {27'd0, WriteAddr}, 32'd0);
        in_valid = 1'b0;
        tick();

        if (c_MUL_EN) begin
            // 32-cycle multiply; ADD offered while busy must be dropped
            op = 4'd8; rs_data = 32'h0001_0003; rt_data = 32'h0002_0005;
            dest_addr = 5'd7; in_valid = 1'b1;
            tick();
            op = 4'd0; rs_data = 32'd1; rt_data = 32'd1; dest_addr = 5'd2;
            for (int i = 0; i < 32; i++) begin
                check("mul_busy", {31'd0, busy}, 32'd1);
                check("mul_not_ready", {31'd0, in_ready}, 32'd0);
                if (i == 31) begin
                    wrExp = 1'b1;
                    sb.push_back('{addr: 5'd7, data: model(4'd8, 32'h0001_0003, 32'h0002_0005)});
                end
                tick();
            end
            in_valid = 1'b0;
            check("mul_data", WriteData, 32'h000B_000F);
            check("mul_done_busy", {31'd0, busy}, 32'd0);
            check("mul_done_ready", {31'd0, in_ready}, 32'd1);
            tick();

            // Reset during multiply aborts it
            op = 4'd8; rs_data = 32'h0000_0003; rt_data = 32'h0000_0003;
            dest_addr = 5'd6; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            for (int i = 0; i < 9; i++) tick();
        end else begin
            // op 8 is illegal in this build
            issue(4'd8, 32'h0001_0003, 32'h0002_0005, 5'd6);
            check("op8_busy", {31'd0, busy}, 32'd0);
            check("op8_ready", {31'd0, in_ready}, 32'd1);
            check("op8_data_held", WriteData, lastData);
            in_valid = 1'b0;
            tick();
        end

        reset = 1'b0;
        #1;
        checkResetOutputs("async_rst");
        tick();
        checkResetOutputs("rst_hold");
        reset = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        check("no_write_after_abort", sb.size(), 32'd0);

        issue(4'd0, 32'd2, 32'd3, 5'd1);
        check("post_rst_add", WriteData, 32'd5);
        check("post_rst_addr", {27'd0, WriteAddr}, 32'd1);
        in_valid = 1'b0;
        tick();
        check("final_sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low; ports named CLK and reset.
REQ-002 The block SHALL have these ports:
  CLK        in   1   clock, all state on posedge
  reset      in   1   async active-low reset
  in_valid   in   1   operation presented
  in_ready   out  1   block can accept an operation this cycle
  op         in   4   operation code (REQ-006)
  rs_data    in   32  operand A, from register file RsData
  rt_data    in   32  operand B, from register file RtData
  dest_addr  in   5   destination register
  regWr      out  1   one-cycle write strobe to register file
  WriteAddr  out  5   write destination
  WriteData  out  32  write result
  busy       out  1   multiply in progress
  err        out  1   one-cycle pulse on illegal op

Function
REQ-003 Transfer SHALL occur on a posedge where in_valid=1 and in_ready=1; op, operands and dest_addr are captured at that edge only.
REQ-004 States SHALL be IDLE and MUL; in_ready=1 in IDLE, 0 in MUL; busy=1 exactly in MUL.
REQ-005 Non-multiply ops SHALL complete in 1 cycle: regWr=1 during the cycle after the accepting edge, state remains IDLE, back-to-back transfers each cycle allowed.
REQ-006 Op encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed, result 0 or 1), 6 SLL (rt_data << rs_data[4:0]), 7 SRL (logical, rt_data >> rs_data[4:0]), 8 MUL; 9-15 illegal.
REQ-007 ADD/SUB/MUL SHALL wrap modulo 2^32; no overflow indication; MUL result is the low 32 bits of the unsigned product.
REQ-008 MUL SHALL be shift-add, one multiplier bit per cycle, 5-bit iteration counter 0..31; accepting edge k enters MUL; regWr=1 during cycle after edge k+32; state IDLE and in_ready=1 in that same cycle.
REQ-009 in_valid during MUL SHALL be ignored, not queued.
REQ-010 Illegal op SHALL produce err=1 for the cycle after acceptance, regWr=0, WriteData unchanged, state IDLE.
REQ-011 dest_addr=0 SHALL suppress regWr (result computed, WriteAddr/WriteData updated, strobe held 0); err unaffected.
REQ-012 WriteAddr/WriteData SHALL be registered and hold last value when regWr=0; regWr and err are 0 in every cycle not specified above.

Reset
REQ-013 reset=0 SHALL immediately force state IDLE, counter 0, regWr=0, err=0, busy=0, WriteAddr=0, WriteData=0, in_ready=0 while reset=0.
REQ-014 Reset mid-multiply SHALL abort the operation with no write; first transfer possible on the first posedge with reset=1.

Configuration
REQ-015 Macro ALU_EXEC_MUL_EN defined: MUL state, counter and op 8 implemented per REQ-008.
REQ-016 Macro ALU_EXEC_MUL_EN undefined: no MUL state or multiplier logic; op 8 treated as illegal per REQ-010; busy tied 0, in_ready=1 whenever out of reset.

Verification
REQ-017 ADD rs=0x7FFFFFFF rt=1 dest=3 -> next cycle regWr=1, WriteAddr=3, WriteData=0x80000000.
REQ-018 SLT rs=0xFFFFFFFF rt=1 dest=4 -> WriteData=1; SRL rs=4 rt=0x80000000 -> WriteData=0x08000000.
REQ-019 MUL rs=0x00010003 rt=0x00020005 dest=7 (MUL_EN) -> busy=1 and in_ready=0 for 32 cycles, regWr=1 in cycle 33 with WriteData=0x000B000F; ADD presented during busy not written.
REQ-020 op=12 dest=5 -> err=1 one cycle, regWr=0; ADD dest=0 -> regWr=0, WriteData updated.
REQ-021 reset=0 at cycle 10 of MUL -> outputs zero asynchronously, no regWr after release; next ADD 2+3 dest=1 -> WriteData=5 one cycle after acceptance.
REQ-022 Without MUL_EN: op 8 -> err=1, busy stays 0, in_ready stays 1.
